// File: rtl/bank_pkg.sv
// Shared defaults and FSM state encoding for the register-bank issue sequencer.
package bank_pkg;
    localparam int DATA_W = 32;
    localparam int AW     = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_e;
endpackage

// File: rtl/bank_issue_if.sv
// Decode command, bank port, operand bundle and writeback signals of the issue sequencer.
interface bank_issue_if #(
    parameter int DATA_W = bank_pkg::DATA_W,
    parameter int AW     = bank_pkg::AW
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [AW-1:0]     cmd_ra1;
    logic [AW-1:0]     cmd_ra2;
    logic [AW-1:0]     cmd_wa;
    logic              cmd_we;

    logic [AW-1:0]     ra1;
    logic [AW-1:0]     ra2;
    logic [DATA_W-1:0] dr1;
    logic [DATA_W-1:0] dr2;
    logic              rw;
    logic [AW-1:0]     wa;
    logic [DATA_W-1:0] din;

    logic              op_valid;
    logic              op_ready;
    logic [DATA_W-1:0] op_a;
    logic [DATA_W-1:0] op_b;
    logic [AW-1:0]     op_wa;
    logic              op_we;

    logic              wb_valid;
    logic [AW-1:0]     wb_wa;
    logic [DATA_W-1:0] wb_data;

    modport master (
        input  cmd_valid, cmd_ra1, cmd_ra2, cmd_wa, cmd_we,
        output cmd_ready,
        output ra1, ra2, rw, wa, din,
        input  dr1, dr2,
        output op_valid, op_a, op_b, op_wa, op_we,
        input  op_ready,
        input  wb_valid, wb_wa, wb_data
    );

    modport slave (
        output cmd_valid, cmd_ra1, cmd_ra2, cmd_wa, cmd_we,
        input  cmd_ready,
        input  ra1, ra2, rw, wa, din,
        output dr1, dr2,
        input  op_valid, op_a, op_b, op_wa, op_we,
        output op_ready,
        output wb_valid, wb_wa, wb_data
    );
endinterface

// File: rtl/bank_scoreboard.sv
// Per-register pending bits: set on issue of a writing command, cleared by writeback, set wins.
module bank_scoreboard #(
    parameter int AW = bank_pkg::AW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_i,
    input  logic [AW-1:0]     set_wa_i,
    input  logic              clr_i,
    input  logic [AW-1:0]     clr_wa_i,
    input  logic [AW-1:0]     chk_ra1_i,
    input  logic [AW-1:0]     chk_ra2_i,
    input  logic [AW-1:0]     chk_wa_i,
    input  logic              chk_we_i,
    output logic              hazard_o
);
    import bank_pkg::*;

    localparam int NREG = 1 << AW;

    logic [NREG-1:0] pending_q;
    logic [NREG-1:0] pending_d;
    logic [NREG-1:0] clr_mask;
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] eff_pending;

    // Kept apart from the set path: hazard feeds cmd_ready, which feeds set_i.
    always_comb begin
        clr_mask = '0;
        if (clr_i) clr_mask[clr_wa_i] = 1'b1;
        eff_pending = pending_q & ~clr_mask;
    end

    always_comb begin
        hazard_o = eff_pending[chk_ra1_i] | eff_pending[chk_ra2_i] |
                   (chk_we_i & eff_pending[chk_wa_i]);
    end

    always_comb begin
        set_mask = '0;
        if (set_i) set_mask[set_wa_i] = 1'b1;
        pending_d = eff_pending | set_mask;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end
endmodule

// File: rtl/bank_issue.sv
// Issue sequencer: fetches two operands from the register bank, hands them downstream,
// forwards writebacks to the bank write port and stalls RAW/WAW hazards.
module bank_issue #(
    parameter int DATA_W = bank_pkg::DATA_W,
    parameter int AW     = bank_pkg::AW
) (
    input logic          clk,
    input logic          rst_n,
    bank_issue_if.master bus
);
    import bank_pkg::*;

    state_e            state_q;
    state_e            state_d;
    logic              hazard;
    logic              accept;
    logic [AW-1:0]     ra1_q;
    logic [AW-1:0]     ra2_q;
    logic [AW-1:0]     op_wa_q;
    logic              op_we_q;
    logic [DATA_W-1:0] op_a_q;
    logic [DATA_W-1:0] op_b_q;

    assign accept = bus.cmd_valid & bus.cmd_ready;

    bank_scoreboard #(.AW(AW)) u_sb (
        .clk       (clk),
        .rst_n     (rst_n),
        .set_i     (accept & bus.cmd_we),
        .set_wa_i  (bus.cmd_wa),
        .clr_i     (bus.wb_valid),
        .clr_wa_i  (bus.wb_wa),
        .chk_ra1_i (bus.cmd_ra1),
        .chk_ra2_i (bus.cmd_ra2),
        .chk_wa_i  (bus.cmd_wa),
        .chk_we_i  (bus.cmd_we),
        .hazard_o  (hazard)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = READ;
            READ:    state_d = HOLD;
            HOLD:    if (bus.op_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = (state_q == IDLE) & ~hazard & rst_n;
        bus.op_valid  = (state_q == HOLD);
    end

    // Bank read data is combinational from ra1/ra2, so capture happens at the end of READ.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra1_q   <= '0;
            ra2_q   <= '0;
            op_wa_q <= '0;
            op_we_q <= 1'b0;
            op_a_q  <= '0;
            op_b_q  <= '0;
        end else begin
            if (accept) begin
                ra1_q   <= bus.cmd_ra1;
                ra2_q   <= bus.cmd_ra2;
                op_wa_q <= bus.cmd_wa;
                op_we_q <= bus.cmd_we;
            end
            if (state_q == READ) begin
                op_a_q <= bus.dr1;
                op_b_q <= bus.dr2;
            end
        end
    end

    assign bus.ra1   = ra1_q;
    assign bus.ra2   = ra2_q;
    assign bus.op_a  = op_a_q;
    assign bus.op_b  = op_b_q;
    assign bus.op_wa = op_wa_q;
    assign bus.op_we = op_we_q;

    assign bus.rw  = bus.wb_valid & rst_n;
    assign bus.wa  = bus.wb_valid ? bus.wb_wa : '0;
    assign bus.din = bus.wb_valid ? bus.wb_data : '0;
endmodule

// File: tb/tb_bank_issue.sv
// Scoreboard bench for bank_issue with a write-through register bank model.
module tb_bank_issue;
    logic clk;
    logic rst_n;

    bank_issue_if bus ();

    bank_issue u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    logic [31:0] mem [32];

    assign bus.dr1 = (bus.rw && bus.wa == bus.ra1) ? bus.din : mem[bus.ra1];
    assign bus.dr2 = (bus.rw && bus.wa == bus.ra2) ? bus.din : mem[bus.ra2];

    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) mem[i] <= 32'd0;
            mem[3] <= 32'd100;
            mem[5] <= 32'd752;
        end else if (bus.rw) begin
            mem[bus.wa] <= bus.din;
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  wa;
        logic        we;
    } bundle_t;

    bundle_t exp_q[$];
    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && bus.op_valid && bus.op_ready) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_bundle: got op_a 0x%0h, expected no bundle", bus.op_a);
            end else begin
                bundle_t e;
                e = exp_q.pop_front();
                chk("op_a", bus.op_a, e.a);
                chk("op_b", bus.op_b, e.b);
                chk("op_wa", 32'(bus.op_wa), 32'(e.wa));
                chk("op_we", 32'(bus.op_we), 32'(e.we));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] wa, input logic we);
        bundle_t e;
        e.a = a; e.b = b; e.wa = wa; e.we = we;
        exp_q.push_back(e);
    endtask

    // Drive a command, wait (bounded) for acceptance, queue its expected bundle.
    task automatic send(input logic [4:0] r1, input logic [4:0] r2, input logic [4:0] w,
                        input logic we, input logic [31:0] ea, input logic [31:0] eb);
        int n;
        bus.cmd_ra1 = r1; bus.cmd_ra2 = r2; bus.cmd_wa = w; bus.cmd_we = we;
        bus.cmd_valid = 1'b1;
        #1;
        n = 0;
        while (!bus.cmd_ready && n < 20) begin
            step();
            n++;
        end
        if (!bus.cmd_ready) chk("send_timeout", 32'(bus.cmd_ready), 32'd1);
        push(ea, eb, w, we);
        step();
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got no finish, expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_ra1 = '0; bus.cmd_ra2 = '0; bus.cmd_wa = '0; bus.cmd_we = 1'b0;
        bus.op_ready = 1'b0;
        bus.wb_valid = 1'b1; bus.wb_wa = 5'd1; bus.wb_data = 32'd5;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("rst_rw", 32'(bus.rw), 32'd0);
        chk("rst_op_valid", 32'(bus.op_valid), 32'd0);
        chk("rst_ra1", 32'(bus.ra1), 32'd0);
        chk("rst_op_a", bus.op_a, 32'd0);
        chk("rst_pending", u_dut.u_sb.pending_q, 32'd0);
        bus.wb_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // Basic fetch with 2-cycle latency and op_ready tied high.
        bus.op_ready = 1'b1;
        bus.cmd_ra1 = 5'd3; bus.cmd_ra2 = 5'd5; bus.cmd_wa = 5'd1; bus.cmd_we = 1'b0;
        #1;
        chk("t1_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        send(5'd3, 5'd5, 5'd1, 1'b0, 32'd100, 32'd752);
        #1;
        chk("t1_ra1", 32'(bus.ra1), 32'd3);
        chk("t1_ra2", 32'(bus.ra2), 32'd5);
        chk("t1_read_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("t1_lat1_op_valid", 32'(bus.op_valid), 32'd0);
        step();
        chk("t1_lat2_op_valid", 32'(bus.op_valid), 32'd1);
        chk("t1_hold_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        step();
        chk("t1_ready_back", 32'(bus.cmd_ready), 32'd1);
        chk("t1_op_valid_clr", 32'(bus.op_valid), 32'd0);

        // RAW stall released by a same-cycle writeback.
        send(5'd0, 5'd0, 5'd7, 1'b1, 32'd0, 32'd0);
        repeat (2) step();
        chk("raw_pending7", 32'(u_dut.u_sb.pending_q[7]), 32'd1);
        bus.cmd_ra1 = 5'd7; bus.cmd_ra2 = 5'd3; bus.cmd_wa = 5'd0; bus.cmd_we = 1'b0;
        bus.cmd_valid = 1'b1;
        #1;
        chk("raw_stall", 32'(bus.cmd_ready), 32'd0);
        step();
        chk("raw_stall2", 32'(bus.cmd_ready), 32'd0);
        bus.wb_valid = 1'b1; bus.wb_wa = 5'd7; bus.wb_data = 32'h55;
        #1;
        chk("raw_unblock", 32'(bus.cmd_ready), 32'd1);
        chk("wp_rw", 32'(bus.rw), 32'd1);
        chk("wp_wa", 32'(bus.wa), 32'd7);
        chk("wp_din", bus.din, 32'h55);
        push(32'h55, 32'd100, 5'd0, 1'b0);
        step();
        bus.cmd_valid = 1'b0;
        bus.wb_valid = 1'b0;
        #1;
        chk("wp_idle_rw", 32'(bus.rw), 32'd0);
        chk("wp_idle_wa", 32'(bus.wa), 32'd0);
        chk("wp_idle_din", bus.din, 32'd0);
        chk("raw_pending_clr", u_dut.u_sb.pending_q, 32'd0);
        repeat (2) step();

        // Writeback landing during READ is captured.
        send(5'd3, 5'd5, 5'd0, 1'b0, 32'd999, 32'd752);
        bus.wb_valid = 1'b1; bus.wb_wa = 5'd3; bus.wb_data = 32'd999;
        step();
        bus.wb_valid = 1'b0;
        step();

        // WAW stall; set wins over a same-cycle clear.
        send(5'd0, 5'd0, 5'd9, 1'b1, 32'd0, 32'd0);
        repeat (2) step();
        chk("waw_pending9", 32'(u_dut.u_sb.pending_q[9]), 32'd1);
        bus.cmd_ra1 = 5'd1; bus.cmd_ra2 = 5'd2; bus.cmd_wa = 5'd9; bus.cmd_we = 1'b1;
        bus.cmd_valid = 1'b1;
        #1;
        chk("waw_stall", 32'(bus.cmd_ready), 32'd0);
        step();
        chk("waw_stall2", 32'(bus.cmd_ready), 32'd0);
        bus.wb_valid = 1'b1; bus.wb_wa = 5'd9; bus.wb_data = 32'h99;
        #1;
        chk("waw_unblock", 32'(bus.cmd_ready), 32'd1);
        push(32'd0, 32'd0, 5'd9, 1'b1);
        step();
        bus.cmd_valid = 1'b0;
        bus.wb_valid = 1'b0;
        #1;
        chk("waw_set_wins", 32'(u_dut.u_sb.pending_q[9]), 32'd1);
        repeat (2) step();
        bus.wb_valid = 1'b1; bus.wb_wa = 5'd9; bus.wb_data = 32'h99;
        step();
        bus.wb_valid = 1'b0;
        #1;
        chk("waw_pending_clr", u_dut.u_sb.pending_q, 32'd0);

        // Backpressure: bundle held stable for 5 cycles.
        bus.op_ready = 1'b0;
        send(5'd3, 5'd5, 5'd2, 1'b0, 32'd999, 32'd752);
        step();
        bus.cmd_ra1 = 5'd0; bus.cmd_ra2 = 5'd0; bus.cmd_wa = 5'd0; bus.cmd_we = 1'b0;
        bus.cmd_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("bp_op_valid", 32'(bus.op_valid), 32'd1);
            chk("bp_op_a", bus.op_a, 32'd999);
            chk("bp_op_b", bus.op_b, 32'd752);
            chk("bp_op_wa", 32'(bus.op_wa), 32'd2);
            chk("bp_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            step();
        end
        bus.op_ready = 1'b1;
        step();
        chk("bp_ready_back", 32'(bus.cmd_ready), 32'd1);
        push(32'd0, 32'd0, 5'd0, 1'b0);
        step();
        bus.cmd_valid = 1'b0;
        #1;
        chk("bp_next_accepted", 32'(bus.op_valid | bus.cmd_ready), 32'd0);
        repeat (2) step();

        // Writeback to a non-pending register.
        bus.wb_valid = 1'b1; bus.wb_wa = 5'd20; bus.wb_data = 32'd1234;
        step();
        bus.wb_valid = 1'b0;
        #1;
        chk("wb20_pending", u_dut.u_sb.pending_q, 32'd0);
        chk("wb20_bank", mem[20], 32'd1234);
        send(5'd20, 5'd20, 5'd0, 1'b0, 32'd1234, 32'd1234);
        repeat (2) step();

        // Asynchronous reset while a bundle is held.
        bus.op_ready = 1'b0;
        send(5'd0, 5'd0, 5'd4, 1'b1, 32'd0, 32'd0);
        step();
        chk("hold_op_valid", 32'(bus.op_valid), 32'd1);
        chk("hold_pending4", 32'(u_dut.u_sb.pending_q[4]), 32'd1);
        bus.wb_valid = 1'b1; bus.wb_wa = 5'd6; bus.wb_data = 32'd77;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_op_valid", 32'(bus.op_valid), 32'd0);
        chk("arst_pending", u_dut.u_sb.pending_q, 32'd0);
        chk("arst_rw", 32'(bus.rw), 32'd0);
        chk("arst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        chk("arst_op_wa", 32'(bus.op_wa), 32'd0);
        chk("arst_op_we", 32'(bus.op_we), 32'd0);
        exp_q.delete();
        bus.wb_valid = 1'b0;
        step();
        rst_n = 1'b1;
        bus.cmd_ra1 = 5'd4; bus.cmd_ra2 = 5'd4; bus.cmd_wa = 5'd4; bus.cmd_we = 1'b1;
        #1;
        chk("post_rst_ready", 32'(bus.cmd_ready), 32'd1);
        bus.op_ready = 1'b1;
        send(5'd4, 5'd4, 5'd4, 1'b1, 32'd0, 32'd0);
        repeat (3) step();

        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
